mem_access_ctrl: RTL

- Sequencer between the MEM pipeline stage and the RAM/UART data-memory wrapper.
- Turns one load/store request into wrapper bus cycles: byte-lane select, store replication, load extraction with sign/zero extension.
- Waits on UART status before and after UART accesses.
- Stalls the pipeline until each access completes and flags misaligned accesses without touching the bus.

---
 rtl/mem_access_ctrl_pkg.sv | 41 ++++
 rtl/mem_access_ctrl_lane_align.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and address helpers for the MEM-stage data-memory sequencer.
// Includes the size codes, UART register addresses, FSM states and the alignment/UART decode helpers.
package mem_access_ctrl_pkg;

    localparam logic [1:0]  SIZE_BYTE       = 2'd0;
    localparam logic [1:0]  SIZE_HALF       = 2'd1;
    localparam logic [1:0]  SIZE_WORD       = 2'd2;

    localparam logic [31:0] UART_DATA_ADDR  = 32'hBFD003F8;
    localparam logic [31:0] UART_FLAG_ADDR  = 32'hBFD003FC;
    localparam logic [31:0] UART_BLOCK_MASK = ~32'h7;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RX,
        ISSUE,
        WAIT_TX,
        DONE
    } state_e;

    // The unused size code 3 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        logic mis;
        mis = 1'b0;
        case (norm_size(size))
            SIZE_HALF: mis = addr[0];
            SIZE_WORD: mis = (addr[1:0] != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_uart(input logic [31:0] addr);
        return (addr & UART_BLOCK_MASK) == (UART_DATA_ADDR & UART_BLOCK_MASK);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering for the data-memory wrapper.
// Store side produces byte enables and replicated data; load side extracts and extends the addressed lane.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_raw >> {addr_lo, 3'b000};
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
        case (norm_size(size))
            SIZE_BYTE: begin
                sel       = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                sel       = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                sel       = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata_raw;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer turning one MEM-stage load/store into wrapper bus cycles, with UART status handshaking.
// Holds the pipeline until the access completes and reports misaligned accesses without a bus cycle.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TX_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall_o,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        excp_adel,
    output logic        excp_ades,
    output logic        tx_timeout,
    output logic        ce_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        tbre,
    input  logic        tsre,
    input  logic        data_ready
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic        txto_q, txto_d;

    logic        req_misaligned;
    logic        req_rx_wait;
    logic        accept;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    mem_lane_align u_lane_align (
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .sign_ext  (signed_q),
        .wdata     (wdata_q),
        .rdata_raw (data_i),
        .sel       (lane_sel),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    assign req_misaligned = is_misaligned(req_addr, req_size);
    assign req_rx_wait    = is_uart(req_addr) && !req_we && (req_addr < UART_FLAG_ADDR);
    assign accept         = (state_q == IDLE) && req_valid && !flush && !req_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
            txto_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            adel_q   <= adel_d;
            ades_q   <= ades_d;
            txto_q   <= txto_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        adel_d   = 1'b0;
        ades_d   = 1'b0;
        txto_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (req_misaligned) begin
                        adel_d = !req_we;
                        ades_d = req_we;
                    end else begin
                        addr_d   = req_addr;
                        size_d   = req_size;
                        signed_d = req_signed;
                        we_d     = req_we;
                        wdata_d  = req_wdata;
                        state_d  = req_rx_wait ? WAIT_RX : ISSUE;
                    end
                end
            end
            WAIT_RX: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (data_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rdata_d = we_q ? 32'h0 : lane_rdata;
                if (we_q && is_uart(addr_q)) begin
                    cnt_d   = '0;
                    state_d = WAIT_TX;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT_TX: begin
                if (tbre && tsre) begin
                    state_d = DONE;
                end else if (cnt_q + 32'd1 == TX_TIMEOUT) begin
                    txto_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A flush while waiting for RX data releases the pipeline in the same cycle.
    always_comb begin
        stall_o   = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        ce_o      = 1'b0;
        we_o      = 1'b0;
        addr_o    = '0;
        sel_o     = '0;
        data_o    = '0;
        case (state_q)
            IDLE:    stall_o = accept;
            WAIT_RX: stall_o = !flush;
            ISSUE: begin
                stall_o = 1'b1;
                ce_o    = 1'b1;
                we_o    = we_q;
                addr_o  = addr_q;
                sel_o   = lane_sel;
                data_o  = lane_wdata;
            end
            WAIT_TX: stall_o = 1'b1;
            DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
            end
            default: stall_o = 1'b0;
        endcase
    end

    assign excp_adel  = adel_q;
    assign excp_ades  = ades_q;
    assign tx_timeout = txto_q;

endmodule
